tiny_fpga_cfg_loader: RTL and testbench

TINY_FPGA_CFG_LOADER -- requirements
Module: tiny_fpga_cfg_loader

---
 rtl/tiny_fpga_pkg.sv | 22 ++
 rtl/tiny_fpga_crc8.sv | 42 ++++
 rtl/tiny_fpga_cfg_loader.sv | 155 +++++++++++++++
 tb/tb_tiny_fpga_cfg_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny_fpga_pkg.sv
// Shared types and constants for the tiny FPGA configuration loader.
// Holds the loader state encoding and the CRC-8 (poly 0x07, init 0x00) bit-step helper.
package tiny_fpga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } cfg_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One serial CRC-8 step: the incoming bit is XORed with the current MSB.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/tiny_fpga_crc8.sv
// CRC-8 accumulator consuming DATA_W bits per enable, bit 0 of each beat first.
// Only instantiated by the loader when TINY_FPGA_CFG_CRC_EN is defined.
module tiny_fpga_crc8
    import tiny_fpga_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [7:0]        crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC8_INIT;
        end else if (en_i) begin
            for (int i = 0; i < DATA_W; i++) begin
                crc_d = crc8_step(crc_d, data_i[i]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/tiny_fpga_cfg_loader.sv
// Streams a configuration bitstream into a shift chain and checks frame length/tlast.
// Optional CRC-8 trailer check when TINY_FPGA_CFG_CRC_EN is defined (trailer assembled LSB first).
module tiny_fpga_cfg_loader
    import tiny_fpga_pkg::*;
#(
    parameter int BITSTREAM_DATA_WIDTH = 1,
    parameter int CHAIN_LEN            = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic [BITSTREAM_DATA_WIDTH-1:0] s_tdata,
    input  logic                            s_tlast,
    output logic                            chain_shift_en,
    output logic [BITSTREAM_DATA_WIDTH-1:0] chain_data,
    output logic                            busy,
    output logic                            cfg_ready,
    output logic                            cfg_error
);

    localparam int W           = BITSTREAM_DATA_WIDTH;
    localparam int CHAIN_BEATS = CHAIN_LEN / W;
    localparam int CNT_W       = $clog2(CHAIN_BEATS + 8) + 1;
`ifdef TINY_FPGA_CFG_CRC_EN
    localparam int TRAILER_BEATS = 8 / W;
`else
    localparam int TRAILER_BEATS = 0;
`endif
    localparam int LAST_BEATS = CHAIN_BEATS + TRAILER_BEATS;

    localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(LAST_BEATS - 1);
    localparam logic [CNT_W-1:0] CHAIN_BEATS_C = CNT_W'(CHAIN_BEATS);

    cfg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_q, shift_d;
    logic [W-1:0]     data_q, data_d;

    logic start_load;
    logic accept;
    logic is_chain_beat;
    logic is_last_beat;
    logic frame_ok;

    assign start_load    = cfg_start && (state_q != ST_LOAD);
    assign accept        = s_tvalid && (state_q == ST_LOAD);
    assign is_chain_beat = (cnt_q < CHAIN_BEATS_C);
    assign is_last_beat  = (cnt_q == LAST_IDX);

`ifdef TINY_FPGA_CFG_CRC_EN
    logic [7:0] crc_calc;
    logic [7:0] rx_crc_q, rx_crc_d;

    tiny_fpga_crc8 #(
        .DATA_W (W)
    ) u_crc8 (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_load),
        .en_i   (accept && is_chain_beat),
        .data_i (s_tdata),
        .crc_o  (crc_calc)
    );

    // Trailer beats shift in from the top, so the first trailer beat ends up in the low bits.
    always_comb begin
        rx_crc_d = rx_crc_q;
        if (start_load) begin
            rx_crc_d = 8'h00;
        end else if (accept && !is_chain_beat) begin
            rx_crc_d = rx_crc_q >> W;
            rx_crc_d[8-W +: W] = s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_crc_q <= 8'h00;
        end else begin
            rx_crc_q <= rx_crc_d;
        end
    end

    assign frame_ok = (rx_crc_d == crc_calc);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cfg_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (is_last_beat) begin
                        state_d = (s_tlast && frame_ok) ? ST_DONE : ST_ERROR;
                    end else if (s_tlast) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_tready  = (state_q == ST_LOAD);
        busy      = (state_q == ST_LOAD);
        cfg_ready = (state_q == ST_DONE);
        cfg_error = (state_q == ST_ERROR);
    end

    // Beat counter saturates rather than wraps; shift strobe covers chain beats only.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = accept && is_chain_beat;
        data_d  = data_q;
        if (start_load) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept && is_chain_beat) begin
            data_d = s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= 1'b0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
        end
    end

    assign chain_shift_en = shift_q;
    assign chain_data     = data_q;

endmodule

// File: tb/tb_tiny_fpga_cfg_loader.sv
// Directed, table-driven bench for tiny_fpga_cfg_loader (W=1, W=2, W=4 instances, CHAIN_LEN=8).
// Expected CRC trailer for data 0x1,0x2 at W=4 is 0x95, sent low nibble first (0x5, 0x9).
module tb_tiny_fpga_cfg_loader;

    localparam int ST_I = 0;
    localparam int ST_L = 1;
    localparam int ST_D = 2;
    localparam int ST_E = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, s_tvalid, s_tlast;
    logic [7:0] s_tdata;
    logic       start1, start2, start4;

    logic       tready1, shift1, busy1, rdy1, err1;
    logic [0:0] cdata1;
    logic       tready2, shift2, busy2, rdy2, err2;
    logic [1:0] cdata2;
    logic       tready4, shift4, busy4, rdy4, err4;
    logic [3:0] cdata4;

    tiny_fpga_cfg_loader #(.BITSTREAM_DATA_WIDTH(1), .CHAIN_LEN(8)) u_w1 (
        .clk(clk), .rst(rst), .cfg_start(start1), .s_tvalid(s_tvalid), .s_tready(tready1),
        .s_tdata(s_tdata[0:0]), .s_tlast(s_tlast), .chain_shift_en(shift1), .chain_data(cdata1),
        .busy(busy1), .cfg_ready(rdy1), .cfg_error(err1));

    tiny_fpga_cfg_loader #(.BITSTREAM_DATA_WIDTH(2), .CHAIN_LEN(8)) u_w2 (
        .clk(clk), .rst(rst), .cfg_start(start2), .s_tvalid(s_tvalid), .s_tready(tready2),
        .s_tdata(s_tdata[1:0]), .s_tlast(s_tlast), .chain_shift_en(shift2), .chain_data(cdata2),
        .busy(busy2), .cfg_ready(rdy2), .cfg_error(err2));

    tiny_fpga_cfg_loader #(.BITSTREAM_DATA_WIDTH(4), .CHAIN_LEN(8)) u_w4 (
        .clk(clk), .rst(rst), .cfg_start(start4), .s_tvalid(s_tvalid), .s_tready(tready4),
        .s_tdata(s_tdata[3:0]), .s_tlast(s_tlast), .chain_shift_en(shift4), .chain_data(cdata4),
        .busy(busy4), .cfg_ready(rdy4), .cfg_error(err4));

    typedef struct {
        string      name;
        int         sel;
        logic       rst;
        logic       start;
        logic       valid;
        logic       tlast;
        logic [7:0] data;
        logic       e_shift;
        logic [7:0] e_data;
        int         e_st;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string name, input int sel, input logic r, input logic s,
                                input logic v, input logic l, input logic [7:0] d,
                                input logic es, input logic [7:0] ed, input int est);
        vec_t t;
        t.name = name; t.sel = sel; t.rst = r; t.start = s; t.valid = v; t.tlast = l;
        t.data = d; t.e_shift = es; t.e_data = ed; t.e_st = est;
        return t;
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {shift,data,tready,busy,ready,error} got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample the selected DUT 1ns after the edge.
    task automatic apply(input vec_t v);
        logic        sh, tr, bz, rd, er, care;
        logic [7:0]  cd;
        logic [12:0] act, exp;
        rst      = v.rst;
        start1   = (v.sel == 1) && v.start;
        start2   = (v.sel == 2) && v.start;
        start4   = (v.sel == 4) && v.start;
        s_tvalid = v.valid;
        s_tlast  = v.tlast;
        s_tdata  = v.data;
        @(posedge clk);
        #1;
        case (v.sel)
            1: begin sh = shift1; cd = {7'd0, cdata1}; tr = tready1; bz = busy1; rd = rdy1; er = err1; end
            2: begin sh = shift2; cd = {6'd0, cdata2}; tr = tready2; bz = busy2; rd = rdy2; er = err2; end
            default: begin sh = shift4; cd = {4'd0, cdata4}; tr = tready4; bz = busy4; rd = rdy4; er = err4; end
        endcase
        care = v.e_shift || v.rst;
        if (!care) cd = 8'h00;
        act = {sh, cd, tr, bz, rd, er};
        exp = {v.e_shift, care ? v.e_data : 8'h00, v.e_st == ST_L, v.e_st == ST_L,
               v.e_st == ST_D, v.e_st == ST_E};
        check(v.name, act, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] clean_bits;
        logic [7:0] bp_bits;
        int         k;
        int         c;

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        clean_bits = 8'b0100_1101;  // beats 1,0,1,1,0,0,1,0 from bit 0
        bp_bits    = 8'h96;

        vq.push_back(mk("reset_w1", 1, 1, 0, 0, 0, 8'h00, 0, 8'h00, ST_I));
        vq.push_back(mk("reset_w1_hold", 1, 1, 1, 1, 1, 8'hFF, 0, 8'h00, ST_I));
        vq.push_back(mk("reset_w2", 2, 1, 0, 0, 0, 8'h00, 0, 8'h00, ST_I));
        vq.push_back(mk("reset_w4", 4, 1, 0, 0, 0, 8'h00, 0, 8'h00, ST_I));

`ifdef TINY_FPGA_CFG_CRC_EN
        vq.push_back(mk("crc_start", 4, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        vq.push_back(mk("crc_beat1", 4, 0, 0, 1, 0, 8'h01, 1, 8'h01, ST_L));
        vq.push_back(mk("crc_beat2", 4, 0, 0, 1, 0, 8'h02, 1, 8'h02, ST_L));
        vq.push_back(mk("crc_trail1", 4, 0, 0, 1, 0, 8'h05, 0, 8'h00, ST_L));
        vq.push_back(mk("crc_trail2_ok", 4, 0, 0, 1, 1, 8'h09, 0, 8'h00, ST_D));
        vq.push_back(mk("crc_done_hold", 4, 0, 0, 1, 0, 8'h03, 0, 8'h00, ST_D));
        vq.push_back(mk("crc_bad_start", 4, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        vq.push_back(mk("crc_bad_beat1", 4, 0, 0, 1, 0, 8'h01, 1, 8'h01, ST_L));
        vq.push_back(mk("crc_bad_beat2", 4, 0, 0, 1, 0, 8'h02, 1, 8'h02, ST_L));
        vq.push_back(mk("crc_bad_trail1", 4, 0, 0, 1, 0, 8'h05, 0, 8'h00, ST_L));
        vq.push_back(mk("crc_bad_trail2", 4, 0, 0, 1, 1, 8'h08, 0, 8'h00, ST_E));
        vq.push_back(mk("crc_err_hold", 4, 0, 0, 0, 0, 8'h00, 0, 8'h00, ST_E));
`else
        // Clean load, W=1, with two idle-wait cycles in LOAD first.
        vq.push_back(mk("clean_start", 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        vq.push_back(mk("clean_wait0", 1, 0, 0, 0, 0, 8'h01, 0, 8'h00, ST_L));
        vq.push_back(mk("clean_wait1", 1, 0, 0, 0, 1, 8'h01, 0, 8'h00, ST_L));
        for (int i = 0; i < 8; i++) begin
            vq.push_back(mk($sformatf("clean_beat%0d", i + 1), 1, 0, 0, 1, i == 7,
                            {7'd0, clean_bits[i]}, 1, {7'd0, clean_bits[i]}, (i == 7) ? ST_D : ST_L));
        end
        vq.push_back(mk("clean_done_valid", 1, 0, 0, 1, 0, 8'h01, 0, 8'h00, ST_D));
        vq.push_back(mk("clean_done_hold", 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, ST_D));

        // Early tlast on beat 5, W=1, started from DONE.
        vq.push_back(mk("early_start", 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        for (int i = 0; i < 5; i++) begin
            vq.push_back(mk($sformatf("early_beat%0d", i + 1), 1, 0, 0, 1, i == 4,
                            8'(i & 1), 1, 8'(i & 1), (i == 4) ? ST_E : ST_L));
        end
        vq.push_back(mk("early_no_shift", 1, 0, 0, 1, 1, 8'h01, 0, 8'h00, ST_E));
        vq.push_back(mk("early_err_hold", 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, ST_E));

        // Missing tlast, W=2, then reload with cfg_start pulsed mid-LOAD (must be ignored).
        vq.push_back(mk("miss_start", 2, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        vq.push_back(mk("miss_beat1", 2, 0, 0, 1, 0, 8'h03, 1, 8'h03, ST_L));
        vq.push_back(mk("miss_beat2", 2, 0, 0, 1, 0, 8'h01, 1, 8'h01, ST_L));
        vq.push_back(mk("miss_beat3", 2, 0, 0, 1, 0, 8'h02, 1, 8'h02, ST_L));
        vq.push_back(mk("miss_beat4", 2, 0, 0, 1, 0, 8'h00, 1, 8'h00, ST_E));
        vq.push_back(mk("miss_err_hold", 2, 0, 0, 1, 1, 8'h03, 0, 8'h00, ST_E));
        vq.push_back(mk("reload_start", 2, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        vq.push_back(mk("reload_beat1", 2, 0, 0, 1, 0, 8'h02, 1, 8'h02, ST_L));
        vq.push_back(mk("reload_beat2_start", 2, 0, 1, 1, 0, 8'h01, 1, 8'h01, ST_L));
        vq.push_back(mk("reload_beat3", 2, 0, 0, 1, 0, 8'h03, 1, 8'h03, ST_L));
        vq.push_back(mk("reload_beat4", 2, 0, 0, 1, 1, 8'h00, 1, 8'h00, ST_D));

        // W=4 plain frame of two beats.
        vq.push_back(mk("w4_start", 4, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        vq.push_back(mk("w4_beat1", 4, 0, 0, 1, 0, 8'h01, 1, 8'h01, ST_L));
        vq.push_back(mk("w4_beat2", 4, 0, 0, 1, 1, 8'h02, 1, 8'h02, ST_D));
`endif

        foreach (vq[i]) apply(vq[i]);

`ifndef TINY_FPGA_CFG_CRC_EN
        // Backpressure: s_tvalid follows 1,0,0,1 repeating until eight beats are accepted.
        apply(mk("bp_start", 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        k = 0;
        c = 0;
        while (k < 8 && c < 64) begin
            if ((c % 4) == 0 || (c % 4) == 3) begin
                apply(mk($sformatf("bp_beat%0d", k + 1), 1, 0, 0, 1, k == 7,
                         {7'd0, bp_bits[k]}, 1, {7'd0, bp_bits[k]}, (k == 7) ? ST_D : ST_L));
                k++;
            end else begin
                apply(mk($sformatf("bp_gap%0d", c), 1, 0, 0, 0, 1,
                         {7'd0, ~bp_bits[k]}, 0, 8'h00, ST_L));
            end
            c++;
        end

        // Reset mid-LOAD right after beat 3: pending shift and all status must clear.
        apply(mk("rstmid_start", 1, 0, 1, 0, 0, 8'h00, 0, 8'h00, ST_L));
        apply(mk("rstmid_beat1", 1, 0, 0, 1, 0, 8'h00, 1, 8'h00, ST_L));
        apply(mk("rstmid_beat2", 1, 0, 0, 1, 0, 8'h01, 1, 8'h01, ST_L));
        apply(mk("rstmid_beat3", 1, 0, 0, 1, 0, 8'h01, 1, 8'h01, ST_L));
        apply(mk("rstmid_rst", 1, 1, 0, 1, 0, 8'h01, 0, 8'h00, ST_I));
        apply(mk("rstmid_idle1", 1, 0, 0, 1, 0, 8'h01, 0, 8'h00, ST_I));
        apply(mk("rstmid_idle2", 1, 0, 0, 1, 1, 8'h01, 0, 8'h00, ST_I));
        apply(mk("rstmid_w2_idle", 2, 0, 0, 0, 0, 8'h00, 0, 8'h00, ST_I));
`endif

        s_tvalid = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
